// File: rtl/mpy_pkg.sv
// Shared encodings for the iterative multiplier/accumulator: opcodes, FSM states
// and the CVNZ status bit positions (same order as the ALU status bits).
package mpy_pkg;

    localparam logic [1:0] OP_MPY  = 2'b00;
    localparam logic [1:0] OP_MPYS = 2'b01;
    localparam logic [1:0] OP_MAC  = 2'b10;
    localparam logic [1:0] OP_MACS = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_ACC  = 2'd3;

    localparam int CVNZ_C = 3;
    localparam int CVNZ_V = 2;
    localparam int CVNZ_N = 1;
    localparam int CVNZ_Z = 0;

    // Opcode bit 0 selects signed operands, bit 1 selects accumulate.
    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_acc(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mpy_shift_add.sv
// Radix-2 shift-add multiplier core: one multiplier bit per step, LSB first,
// with the multiplicand shifted left into a double-width partial product.
module mpy_shift_add #(
    parameter int SIZE = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      step,
    input  logic [SIZE-1:0]           mcand_in,
    input  logic [SIZE-1:0]           mplier_in,
    input  logic [$clog2(SIZE)-1:0]   cnt_init,
    output logic [2*SIZE-1:0]         product,
    output logic                      last
);
    import mpy_pkg::*;

    localparam int CW = $clog2(SIZE);

    logic [2*SIZE-1:0] mcand_q, mcand_d;
    logic [SIZE-1:0]   mplier_q, mplier_d;
    logic [2*SIZE-1:0] prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{SIZE{1'b0}}, mcand_in};
            mplier_d = mplier_in;
            prod_d   = '0;
            cnt_d    = cnt_init;
        end else if (step) begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product = prod_q;
    assign last    = (cnt_q == '0);

endmodule

// File: rtl/mpy_unit.sv
// Multi-cycle MPY/MPYS/MAC/MACS unit: FSM, operand sign/width conditioning,
// persistent accumulator with SUMEXT extension and CVNZ status.
module mpy_unit #(
    parameter int SIZE = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [1:0]          OP,
    input  logic                BW,
    input  logic [SIZE-1:0]     OP1,
    input  logic [SIZE-1:0]     OP2,
    input  logic                CLR_ACC,
    output logic                BUSY,
    output logic                DONE,
    output logic [2*SIZE-1:0]   RES,
    output logic [SIZE-1:0]     SUMEXT,
    output logic [3:0]          CVNZ_mpy,
    output logic [1:0]          state_dbg
);
    import mpy_pkg::*;

    localparam int HALF = SIZE / 2;
    localparam int CW   = $clog2(SIZE);
    localparam int MSB  = 2 * SIZE - 1;

    // Handshake: START is taken only on a cycle where BUSY=0 (including the DONE
    // cycle); once taken, BUSY stays high until ACC completes and DONE pulses once.
    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [2*SIZE-1:0] prod_q, prod_d;
    logic [2*SIZE-1:0] res_q, res_d;
    logic [SIZE-1:0]   sumext_q, sumext_d;
    logic [3:0]        cvnz_q, cvnz_d;
    logic              done_q, done_d;

    logic [SIZE-1:0]   op1_ext, op2_ext, op1_mag, op2_mag;
    logic              op1_neg, op2_neg;
    logic [CW-1:0]     cnt_init;
    logic              sa_load, sa_step, sa_last;
    logic [2*SIZE-1:0] mul_prod;

    always_comb begin
        op1_ext = OP1;
        op2_ext = OP2;
        if (BW) begin
            op1_ext = op_is_signed(OP) ? {{HALF{OP1[HALF-1]}}, OP1[HALF-1:0]}
                                       : {{HALF{1'b0}}, OP1[HALF-1:0]};
            op2_ext = op_is_signed(OP) ? {{HALF{OP2[HALF-1]}}, OP2[HALF-1:0]}
                                       : {{HALF{1'b0}}, OP2[HALF-1:0]};
        end
        op1_neg = op_is_signed(OP) & op1_ext[SIZE-1];
        op2_neg = op_is_signed(OP) & op2_ext[SIZE-1];
        // The most-negative value negates to 2^(SIZE-1), still representable unsigned.
        op1_mag = op1_neg ? (~op1_ext) + SIZE'(1) : op1_ext;
        op2_mag = op2_neg ? (~op2_ext) + SIZE'(1) : op2_ext;
        cnt_init = BW ? CW'(HALF - 1) : CW'(SIZE - 1);
    end

    mpy_shift_add #(.SIZE(SIZE)) u_shift_add (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (sa_load),
        .step      (sa_step),
        .mcand_in  (op1_mag),
        .mplier_in (op2_mag),
        .cnt_init  (cnt_init),
        .product   (mul_prod),
        .last      (sa_last)
    );

    logic [2*SIZE:0]   acc_sum;
    logic [2*SIZE-1:0] new_res;
    logic              acc_c, acc_v;

    assign acc_sum = {1'b0, res_q} + {1'b0, prod_q};
    assign new_res = op_is_acc(op_q) ? acc_sum[MSB:0] : prod_q;
    assign acc_c   = (op_q == OP_MAC) & acc_sum[2*SIZE];
    assign acc_v   = (op_q == OP_MACS) & (res_q[MSB] == prod_q[MSB])
                   & (acc_sum[MSB] != res_q[MSB]);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        res_d    = res_q;
        sumext_d = sumext_q;
        cvnz_d   = cvnz_q;
        done_d   = 1'b0;
        sa_load  = 1'b0;
        sa_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Clear lands on the same edge as acceptance, so MAC adds onto zero.
                if (CLR_ACC) begin
                    res_d    = '0;
                    sumext_d = '0;
                    cvnz_d   = '0;
                end
                if (START) begin
                    state_d = S_CALC;
                    op_d    = OP;
                    neg_d   = op1_neg ^ op2_neg;
                    sa_load = 1'b1;
                end
            end
            S_CALC: begin
                sa_step = 1'b1;
                if (sa_last) state_d = S_FIX;
            end
            S_FIX: begin
                prod_d  = neg_q ? (~mul_prod) + (2*SIZE)'(1) : mul_prod;
                state_d = S_ACC;
            end
            S_ACC: begin
                res_d = new_res;
                case (op_q)
                    OP_MPY:  sumext_d = '0;
                    OP_MAC:  sumext_d = {{(SIZE-1){1'b0}}, acc_c};
                    default: sumext_d = {SIZE{new_res[MSB]}};
                endcase
                cvnz_d         = '0;
                cvnz_d[CVNZ_C] = acc_c;
                cvnz_d[CVNZ_V] = acc_v;
                cvnz_d[CVNZ_N] = new_res[MSB];
                cvnz_d[CVNZ_Z] = (new_res == '0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            res_q    <= '0;
            sumext_q <= '0;
            cvnz_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            res_q    <= res_d;
            sumext_q <= sumext_d;
            cvnz_q   <= cvnz_d;
            done_q   <= done_d;
        end
    end

    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign RES       = res_q;
    assign SUMEXT    = sumext_q;
    assign CVNZ_mpy  = cvnz_q;
    assign state_dbg = state_q;

endmodule
